// File: rtl/sr_mul_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
// Imported by sr_mul_step and sr_mul_seq.
package sr_mul_pkg;

  localparam int MUL_WIDTH = 32;

  typedef enum logic [1:0] {
    MUL_IDLE,
    MUL_BUSY,
    MUL_DONE
  } mul_state_t;

endpackage

// File: rtl/sr_mul_step.sv
// One shift-add step of the multiplier: conditional add of the
// multiplicand, then shift multiplicand left and multiplier right.
module sr_mul_step
  import sr_mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] mcand,
  input  logic [WIDTH-1:0] mplier,
  output logic [WIDTH-1:0] accNext,
  output logic [WIDTH-1:0] mcandNext,
  output logic [WIDTH-1:0] mplierNext
);

  // add-if-lsb, then shift both operands by one bit
  always_comb begin
    accNext    = mplier[0] ? acc + mcand : acc;
    mcandNext  = mcand << 1;
    mplierNext = mplier >> 1;
  end

endmodule

// File: rtl/sr_mul_seq.sv
// Sequential shift-add multiplier returning the low WIDTH bits of a*b.
// Optional macro SR_MUL_EARLY_EXIT_EN: finish once the multiplier empties.
module sr_mul_seq
  import sr_mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mul_req,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic             stall,
  output logic [WIDTH-1:0] result,
  output logic             result_valid
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  mul_state_t state;
  mul_state_t nextState;

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] accNext;
  logic [WIDTH-1:0] mcandNext;
  logic [WIDTH-1:0] mplierNext;
  logic             lastStep;

  sr_mul_step #(
    .WIDTH(WIDTH)
  ) step (
    .acc       (acc),
    .mcand     (mcand),
    .mplier    (mplier),
    .accNext   (accNext),
    .mcandNext (mcandNext),
    .mplierNext(mplierNext)
  );

`ifdef SR_MUL_EARLY_EXIT_EN
  assign lastStep = (cnt == LAST) || (mplierNext == '0);
`else
  assign lastStep = (cnt == LAST);
`endif

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= MUL_IDLE;
    else     state <= nextState;
  end

  // next state, stall and valid decode
  always_comb begin
    nextState    = state;
    stall        = 1'b0;
    result_valid = 1'b0;
    unique case (state)
      MUL_IDLE: begin
        if (mul_req) begin
          stall     = 1'b1;
          nextState = MUL_BUSY;
        end
      end
      MUL_BUSY: begin
        stall = 1'b1;
        if (lastStep) nextState = MUL_DONE;
      end
      MUL_DONE: begin
        result_valid = 1'b1;
        nextState    = MUL_IDLE;
      end
      default: nextState = MUL_IDLE;
    endcase
  end

  // operand capture, iteration and result latch
  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      result <= '0;
    end else begin
      unique case (state)
        MUL_IDLE: begin
          if (mul_req) begin
            mcand  <= srcA;
            mplier <= srcB;
            acc    <= '0;
            cnt    <= '0;
          end
        end
        MUL_BUSY: begin
          acc    <= accNext;
          mcand  <= mcandNext;
          mplier <= mplierNext;
          cnt    <= cnt + 1'b1;
          if (lastStep) result <= accNext;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sr_mul_seq.sv
// Self-checking bench for sr_mul_seq against a plain-arithmetic model.
// Latency model follows SR_MUL_EARLY_EXIT_EN when it is defined.
module tb_sr_mul_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         mul_req;
  logic [W-1:0] srcA;
  logic [W-1:0] srcB;
  logic         stall;
  logic [W-1:0] result;
  logic         result_valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sr_mul_seq #(
    .WIDTH(W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mul_req     (mul_req),
    .srcA        (srcA),
    .srcB        (srcB),
    .stall       (stall),
    .result      (result),
    .result_valid(result_valid)
  );

  task automatic check(input string tag, input logic [W-1:0] got,
                       input logic [W-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int bitlen(input logic [W-1:0] v);
    int n = 0;
    for (int i = 0; i < W; i++)
      if (v[i]) n = i + 1;
    return n;
  endfunction

  // cycles from capture cycle t to the DONE cycle
  function automatic int expLat(input logic [W-1:0] b);
`ifdef SR_MUL_EARLY_EXIT_EN
    return 1 + ((bitlen(b) > 1) ? bitlen(b) : 1);
`else
    return W + 1;
`endif
  endfunction

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input string tag);
    @(negedge clk);
    srcA    = a;
    srcB    = b;
    mul_req = 1'b1;
    #1;
    check({tag, "/capStall"}, W'(stall), W'(1));
  endtask

  task automatic waitDone(input logic [W-1:0] expRes, input int lat,
                          input int dropAt, input string tag);
    bit seen = 0;
    for (int k = 1; k <= W + 4 && !seen; k++) begin
      @(negedge clk);
      if (k == dropAt) begin
        mul_req = 1'b0;
        srcA    = $urandom;
        srcB    = $urandom;
      end
      #1;
      if (result_valid) begin
        seen = 1;
        check({tag, "/lat"}, W'(k), W'(lat));
        check({tag, "/res"}, result, expRes);
        check({tag, "/doneStall"}, W'(stall), W'(0));
      end else begin
        check({tag, "/busyStall"}, W'(stall), W'(1));
      end
    end
    if (!seen) check({tag, "/timeout"}, W'(result_valid), W'(1));
  endtask

  task automatic idleCheck(input logic [W-1:0] expRes, input string tag);
    @(negedge clk);
    mul_req = 1'b0;
    #1;
    check({tag, "/validFall"}, W'(result_valid), W'(0));
    check({tag, "/idleStall"}, W'(stall), W'(0));
    check({tag, "/hold"}, result, expRes);
  endtask

  task automatic runOp(input logic [W-1:0] a, input logic [W-1:0] b,
                       input int dropAt, input string tag);
    logic [W-1:0] p;
    p = a * b;
    issue(a, b, tag);
    waitDone(p, expLat(b), dropAt, tag);
    idleCheck(p, tag);
  endtask

  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] p;

    rst     = 1'b1;
    mul_req = 1'b0;
    srcA    = '0;
    srcB    = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst/result", result, '0);
    check("rst/valid", W'(result_valid), W'(0));
    check("rst/stall0", W'(stall), W'(0));
    mul_req = 1'b1;
    #1;
    check("rst/stall1", W'(stall), W'(1));
    mul_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    runOp(32'd3, 32'd5, 0, "3x5");
    runOp(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "ones");
    runOp(32'h8000_0000, 32'd2, 0, "msbx2");
    runOp(32'd9, 32'd9, 5, "9x9drop");

    // reset at t+10 with mul_req held, restart at t+11
    a = 32'h0000_DEAD;
    b = 32'h8000_0003;
    issue(a, b, "rstMid");
    for (int i = 1; i <= 10; i++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rstMid/result", result, '0);
    check("rstMid/valid", W'(result_valid), W'(0));
    check("rstMid/restart", W'(stall), W'(1));
    p = a * b;
    waitDone(p, expLat(b), 0, "rstMid2");
    idleCheck(p, "rstMid2");

    // back-to-back with mul_req held through DONE
    issue(32'd7, 32'd6, "b2b1");
    waitDone(32'd42, expLat(32'd6), 0, "b2b1");
    issue(32'h0001_0000, 32'h0001_0000, "b2b2");
    waitDone(32'd0, expLat(32'h0001_0000), 0, "b2b2");
    idleCheck(32'd0, "b2b2");

    runOp(32'h1234_5678, 32'd1, 0, "x1");
    runOp(32'h0000_ABCD, 32'd0, 0, "x0");
    runOp(32'd2, 32'h8000_0000, 0, "2xmsb");

    for (int n = 0; n < 8; n++) begin
      a = $urandom;
      b = $urandom;
      b = b >> $urandom_range(0, 31);
      runOp(a, b, $urandom_range(1, 6), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
